// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side bus responder: FSM state type,
// reset vector and the stall-generator LFSR step.
package mem_responder_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_resp_state_t;

  localparam logic [31:0] MEM_RESET_VECTOR = 32'hBFC00000;

  // Feedback taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// 8-bit maximal-length LFSR; steps once per adv_i pulse and supplies the
// pseudo-random wait-state count.
module mem_stall_lfsr
  import mem_responder_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  output logic [7:0] value_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Slave end of the CPU read/write/byte-enable/waitrequest memory bus: a
// word-addressed RAM window with fixed or pseudo-random wait states.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = MEM_RESET_VECTOR,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          STALL_MODE  = 1'b0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     address_i,
  input  logic            read_i,
  input  logic            write_i,
  input  logic [3:0]      byte_en_i,
  input  logic [31:0]     writedata_i,
  output logic            waitrequest_o,
  output logic [31:0]     readdata_o,
  output logic            err_o,
  output mem_resp_state_t dbg_state_o
);

  // Handshake: a request is read_i^write_i. It is accepted on the first
  // cycle it is present with waitrequest_o=0; until then the master holds
  // address, data, byte enables and the request bits stable.

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam int          CNT_W    = 16;
  localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT    = BASE_EXT + (33'(MEM_WORDS) << 2);

  mem_resp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [MEM_WORDS];

  logic             req;
  logic             addr_ok;
  logic [AW-1:0]    word_idx;
  logic [7:0]       lfsr_val;
  logic [31:0]      rand_n;
  logic [CNT_W-1:0] n_sel;
  logic             wait_req;
  logic             accept;
  logic             err_set;

  assign req      = read_i ^ write_i;
  assign addr_ok  = ({1'b0, address_i} >= BASE_EXT) &&
                    ({1'b0, address_i} < LIMIT) &&
                    (address_i[1:0] == 2'b00);
  assign word_idx = AW'((address_i - BASE_ADDR) >> 2);

  mem_stall_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (accept),
    .value_o (lfsr_val)
  );

  // Wait count is sampled only in IDLE; the LFSR holds still until acceptance.
  assign rand_n = 32'(lfsr_val) % (32'(WAIT_CYCLES) + 32'd1);
  assign n_sel  = STALL_MODE ? CNT_W'(rand_n) : CNT_W'(WAIT_CYCLES);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_req = 1'b0;
    accept   = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (read_i && write_i) begin
          err_set = 1'b1;
        end else if (req) begin
          if (n_sel == '0) begin
            accept = 1'b1;
          end else begin
            wait_req = 1'b1;
            cnt_d    = n_sel - 1'b1;
            state_d  = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (!req) begin
          // Dropped or conflicting request: abandon without touching the RAM.
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = MEM_IDLE;
        end else if (cnt_q != '0) begin
          wait_req = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else begin
          accept  = 1'b1;
          state_d = MEM_IDLE;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!rst_n) begin
      wait_req = 1'b1;
      accept   = 1'b0;
      err_set  = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (accept && read_i) begin
      rdata_d = addr_ok ? mem_q[word_idx] : 32'h0;
    end
    err_d = err_q | err_set | (accept & ~addr_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is never reset; only enabled byte lanes of an in-range write change.
  always_ff @(posedge clk) begin
    if (accept && write_i && addr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en_i[k]) begin
          mem_q[word_idx][8*k +: 8] <= writedata_i[8*k +: 8];
        end
      end
    end
  end

  assign waitrequest_o = wait_req;
  assign readdata_o    = rdata_q;
  assign err_o         = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (2 fixed waits, 0 waits, 3 fixed
// waits, 0..3 random waits) driven one at a time through a shared access task.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NI = 4;
  localparam int NV = 10;

  logic            clk;
  logic            rst_n_s [NI];
  logic [31:0]     addr_s  [NI];
  logic            rd_s    [NI];
  logic            wr_s    [NI];
  logic [3:0]      be_s    [NI];
  logic [31:0]     wd_s    [NI];
  logic            wreq_s  [NI];
  logic [31:0]     rdata_s [NI];
  logic            err_s   [NI];
  mem_resp_state_t st_s    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .MEM_WORDS   (4096),
      .BASE_ADDR   (32'hBFC00000),
      .WAIT_CYCLES ((g == 0) ? 2 : (g == 1) ? 0 : 3),
      .STALL_MODE  (g == 3),
      .LFSR_SEED   (8'hA5)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n_s[g]),
      .address_i     (addr_s[g]),
      .read_i        (rd_s[g]),
      .write_i       (wr_s[g]),
      .byte_en_i     (be_s[g]),
      .writedata_i   (wd_s[g]),
      .waitrequest_o (wreq_s[g]),
      .readdata_o    (rdata_s[g]),
      .err_o         (err_s[g]),
      .dbg_state_o   (st_s[g])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: one full bus transaction on instance k; returns the number of
  // waitrequest cycles seen and the read data registered after acceptance.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int waits,
                        output logic [31:0] rdata);
    @(negedge clk);
    rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; be_s[k] = be; wd_s[k] = wd;
    waits = 0;
    #1;
    while (wreq_s[k] !== 1'b0 && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 40) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: inst %0d waitrequest still %b after %0d cycles", k, wreq_s[k], waits);
    end
    @(posedge clk);
    #1;
    rd_s[k] = 1'b0; wr_s[k] = 1'b0;
    rdata = rdata_s[k];
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          exp_waits;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [NV];
  int          waits;
  logic [31:0] rdat;
  logic [31:0] b2b_words [4];
  logic [7:0]  lm;
  int          w;
  int          exp_n;
  int          seen [4];
  logic [31:0] ref_mem [16];
  logic [31:0] d;
  logic [3:0]  b;
  logic        isrd;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'h24020005, 2, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0,        2, 1'b1, 32'h24020005};
    vecs[2] = '{1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'h11223344, 2, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'hBFC00010, 4'h5, 32'hAABBCCDD, 2, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'hBFC00010, 4'h0, 32'h0,        2, 1'b1, 32'h11BB33DD};
    vecs[5] = '{1'b0, 1'b1, 32'hBFC03FFC, 4'hF, 32'hCAFEF00D, 2, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'hBFC03FFC, 4'h3, 32'h0,        2, 1'b1, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 32'hBFC00010, 4'h0, 32'hFFFFFFFF, 2, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'hBFC00010, 4'h0, 32'h0,        2, 1'b1, 32'h11BB33DD};
    vecs[9] = '{1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0,        2, 1'b1, 32'h24020005};

    for (int k = 0; k < NI; k++) begin
      rst_n_s[k] = 1'b0; rd_s[k] = 1'b0; wr_s[k] = 1'b0;
      addr_s[k] = '0; be_s[k] = '0; wd_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_wreq_during_reset", 32'(wreq_s[0]), 32'd1);
    for (int k = 0; k < NI; k++) rst_n_s[k] = 1'b1;
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_wreq", 32'(wreq_s[k]), 32'd0);
      check("rst_rdata", rdata_s[k], 32'h0);
      check("rst_err", 32'(err_s[k]), 32'd0);
      check("rst_state", 32'(st_s[k]), 32'(MEM_IDLE));
    end

    // Table-driven accesses, instance 0 (2 fixed wait states)
    for (int i = 0; i < NV; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, waits, rdat);
      check("vec_waits", 32'(waits), 32'(vecs[i].exp_waits));
      if (vecs[i].chk_rd) check("vec_rdata", rdat, vecs[i].exp_rd);
      check("vec_err", 32'(err_s[0]), 32'd0);
    end

    // Write dropped while waiting: no RAM update, sticky error, back to IDLE
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 32'hBFC00000; be_s[0] = 4'hF; wd_s[0] = 32'hDEADBEEF;
    #1 check("drop_wreq_t0", 32'(wreq_s[0]), 32'd1);
    @(negedge clk);
    #1 check("drop_state_wait", 32'(st_s[0]), 32'(MEM_WAIT));
    wr_s[0] = 1'b0;
    @(negedge clk);
    #1 check("drop_state_idle", 32'(st_s[0]), 32'(MEM_IDLE));
    check("drop_err", 32'(err_s[0]), 32'd1);
    access(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, waits, rdat);
    check("drop_no_write", rdat, 32'h24020005);

    // Reset clears readdata/err but not the RAM
    @(negedge clk);
    rst_n_s[0] = 1'b0;
    @(negedge clk);
    #1 check("rst2_rdata", rdata_s[0], 32'h0);
    check("rst2_err", 32'(err_s[0]), 32'd0);
    rst_n_s[0] = 1'b1;

    // Out-of-range and past-the-end accesses
    access(0, 1'b1, 1'b0, 32'h00000000, 4'h0, 32'h0, waits, rdat);
    check("oor_waits", 32'(waits), 32'd2);
    check("oor_rdata", rdat, 32'h0);
    check("oor_err", 32'(err_s[0]), 32'd1);
    access(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, waits, rdat);
    check("ram_kept_over_reset", rdat, 32'h24020005);
    access(0, 1'b1, 1'b0, 32'hBFC04000, 4'h0, 32'h0, waits, rdat);
    check("end_rdata", rdat, 32'h0);
    access(0, 1'b0, 1'b1, 32'hBFC04000, 4'hF, 32'hFFFFFFFF, waits, rdat);
    access(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, waits, rdat);
    check("end_no_wrap", rdat, 32'h24020005);
    check("err_sticky", 32'(err_s[0]), 32'd1);

    // Instance 1 (0 wait states): back-to-back reads at one per cycle
    for (int i = 0; i < 4; i++) begin
      b2b_words[i] = 32'hA0000000 + 32'(i) * 32'h01010101;
      access(1, 1'b0, 1'b1, 32'hBFC00000 + 32'(4 * i), 4'hF, b2b_words[i], waits, rdat);
      check("w0_write_waits", 32'(waits), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_s[1] = 1'b1; addr_s[1] = 32'hBFC00000 + 32'(4 * i);
      #1 check("b2b_wreq", 32'(wreq_s[1]), 32'd0);
      if (i > 0) check("b2b_rdata", rdata_s[1], b2b_words[i-1]);
    end
    @(negedge clk);
    rd_s[1] = 1'b0;
    #1 check("b2b_rdata_last", rdata_s[1], b2b_words[3]);
    check("b2b_err", 32'(err_s[1]), 32'd0);
    access(1, 1'b0, 1'b1, 32'hBFC00002, 4'hF, 32'h55555555, waits, rdat);
    check("misalign_err", 32'(err_s[1]), 32'd1);
    access(1, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, waits, rdat);
    check("misalign_no_write", rdat, b2b_words[0]);

    // Instance 2 (3 wait states): reset on the second wait cycle of a write
    access(2, 1'b0, 1'b1, 32'hBFC00020, 4'hF, 32'h12345678, waits, rdat);
    check("w3_waits", 32'(waits), 32'd3);
    @(negedge clk);
    wr_s[2] = 1'b1; addr_s[2] = 32'hBFC00020; be_s[2] = 4'hF; wd_s[2] = 32'h87654321;
    #1 check("rstw_wreq_t0", 32'(wreq_s[2]), 32'd1);
    @(negedge clk);
    rst_n_s[2] = 1'b0;
    #1 check("rstw_wreq_in_reset", 32'(wreq_s[2]), 32'd1);
    @(negedge clk);
    #1 check("rstw_state", 32'(st_s[2]), 32'(MEM_IDLE));
    rst_n_s[2] = 1'b1; wr_s[2] = 1'b0;
    access(2, 1'b1, 1'b0, 32'hBFC00020, 4'h0, 32'h0, waits, rdat);
    check("rstw_old_word", rdat, 32'h12345678);
    check("rstw_err", 32'(err_s[2]), 32'd0);
    // Read and write together: no request, no wait, error flagged
    @(negedge clk);
    rd_s[2] = 1'b1; wr_s[2] = 1'b1; wd_s[2] = 32'h0BADF00D;
    #1 check("rw_both_wreq", 32'(wreq_s[2]), 32'd0);
    @(negedge clk);
    rd_s[2] = 1'b0; wr_s[2] = 1'b0;
    #1 check("rw_both_err", 32'(err_s[2]), 32'd1);
    check("rw_both_state", 32'(st_s[2]), 32'(MEM_IDLE));
    check("rw_both_rdata", rdata_s[2], 32'h12345678);

    // Instance 3: random waits 0..3 predicted by a reference LFSR
    lm = 8'hA5;
    for (int n = 0; n < 4; n++) seen[n] = 0;
    for (int i = 0; i < 200; i++) begin
      w    = (i < 16) ? i : int'($urandom_range(0, 15));
      isrd = (i < 16) ? 1'b0 : 1'($urandom_range(0, 1));
      b    = (i < 16) ? 4'hF : 4'($urandom_range(0, 15));
      d    = $urandom;
      exp_n = int'(lm % 8'd4);
      if (isrd) exp_q.push_back(ref_mem[w]);
      access(3, isrd, ~isrd, 32'hBFC00000 + 32'(4 * w), b, d, waits, rdat);
      check("rnd_waits", 32'(waits), 32'(exp_n));
      checks++;
      if (waits < 0 || waits > 3) begin
        failures++;
        $display("FAIL rnd_wait_range: got %0d expected 0..3", waits);
      end else begin
        seen[waits]++;
      end
      if (isrd) begin
        check("rnd_rdata", rdat, exp_q.pop_front());
      end else begin
        for (int k = 0; k < 4; k++) if (b[k]) ref_mem[w][8*k +: 8] = d[8*k +: 8];
      end
      lm = {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};
    end
    for (int n = 0; n < 4; n++) check("rnd_seen", 32'(seen[n] > 0), 32'd1);
    check("rnd_err", 32'(err_s[3]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
